tile_writer: RTL and testbench
==============================

# tile_writer

Streaming write-side loader for the tile colour memory. It accepts a run of pixels on a valid/ready stream and writes them to consecutive addresses of a 2^ADDRESS × COLOR_BITS tile RAM through a registered write port. Transfers start from a programmable base address and wrap modulo memory size. The block sits between the pixel/DMA source and the write port of the tile RAM, whose read side feeds the display path.

## Interface
- ADDRESS, 13, tile RAM address width; depth = 2^ADDRESS words
- COLOR_BITS, 24, pixel word width (24 or 12)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; honoured only in IDLE
- base_addr  in  ADDRESS  first write address, sampled with start
- length  in  ADDRESS+1  pixel count, sampled with start; values above 2^ADDRESS clamp to 2^ADDRESS
- abort  in  1  terminate the current transfer
- s_valid  in  1  pixel stream valid
- s_data  in  COLOR_BITS  pixel stream data
- s_ready  out  1  pixel stream ready
- we  out  1  RAM write enable (registered)
- waddr  out  ADDRESS  RAM write address (registered)
- wdata  out  COLOR_BITS  RAM write data (registered)
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse at transfer completion
- err  out  1  sticky command error flag

## Operation
- States: IDLE, LOAD, DONE.
- IDLE, start=1, clamped length≠0: latch cur_addr=base_addr and remaining=clamped length; go to LOAD; clear err.
- IDLE, start=1, length=0: go to DONE with no writes; clear err.
- LOAD:
  - s_ready = (state==LOAD) && !abort, combinational.
  - Beat = s_valid && s_ready.
  - Each beat: next cycle we=1, waddr=cur_addr, wdata=s_data.
  - After each beat: cur_addr increments mod 2^ADDRESS (0x1FFF → 0x0000 wraps) and remaining decrements.
  - Beat with remaining=1: go to DONE.
  - No beat: we=0 next cycle; s_valid may stall indefinitely.
- LOAD, abort=1: no beat; go to IDLE; no done pulse; set err.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start outside IDLE: ignored; set err. abort outside LOAD: ignored.
- Simultaneous start and abort in IDLE: start wins.
- Address and remaining count arithmetic are unsigned. The remaining counter is ADDRESS+1 bits, so a full 2^ADDRESS-word transfer is legal and rewrites every word once.

## Timing
- Reset values (asynchronous, rst_n=0): state=IDLE, s_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0. Reset mid-transfer discards the transfer with no done pulse. RAM contents are untouched.
- start→s_ready: 1 cycle. start is sampled at edge T; s_ready is high from T+1.
- Beat→write: 1 cycle. A beat at edge N gives we/waddr/wdata valid during the cycle after edge N, i.e. committed at edge N+1.
- The last beat at edge N gives state=DONE during N..N+1. done=1 in the same cycle as the final we=1. busy drops after edge N+1.
- length=0: done=1 in the cycle after start. we stays 0.
- Maximum throughput: 1 pixel/cycle. A length-L transfer with no stalls takes L+2 cycles from start to the return to IDLE.
- done, we and busy are glitch-free registered outputs. s_ready is combinational from state and abort only, never from s_valid.

## Test plan
- Basic load:
  - Stimulus: base_addr=0x0010, length=4, s_valid held high with data 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF.
  - Required: we high 4 consecutive cycles at waddr 0x0010–0x0013 with matching wdata; done pulses with the 4th write; busy low afterwards.
  - Check: a tile-memory model reads back all four words.
- Wrap and stalls:
  - Stimulus: base_addr=0x1FFE, length=4, s_valid toggling 1,0,1,1,0,1.
  - Required: writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001 only on accepted beats; we=0 in stall cycles; single done.
- Zero/clamp lengths:
  - length=0: done one cycle after start; no we; s_ready never high.
  - length=0x3FFF: clamps to 8192; exactly 8192 writes covering every address once.
- Abort:
  - Stimulus: length=8, abort asserted after 3 beats while s_valid=1.
  - Required: s_ready low in the abort cycle; exactly 3 writes; no done; err=1; next valid start clears err.
- Command error:
  - Stimulus: start pulsed while in LOAD with base_addr=0x0100.
  - Required: ignored, so the transfer continues at its original addresses; err=1 sticky until the next start in IDLE.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously during LOAD after 2 beats.
  - Required: all outputs reach their reset values immediately without a clock edge; no done; after release, a fresh length=1 transfer completes normally.

Source files
------------

// File: rtl/tile_writer.sv
// Streaming loader for the tile colour RAM: accepts a valid/ready pixel run and
// writes it to consecutive, wrapping addresses through a registered write port.
module tile_writer #(
  parameter int ADDRESS    = 13,
  parameter int COLOR_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDRESS-1:0]    base_addr,
  input  logic [ADDRESS:0]      length,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [COLOR_BITS-1:0] s_data,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDRESS-1:0]    waddr,
  output logic [COLOR_BITS-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDRESS:0]   DEPTH     = {1'b1, {ADDRESS{1'b0}}};
  localparam logic [ADDRESS:0]   CNT_ONE   = {{ADDRESS{1'b0}}, 1'b1};
  localparam logic [ADDRESS-1:0] ADDR_ONE  = {{(ADDRESS-1){1'b0}}, 1'b1};

  state_t                  state_reg;
  logic [ADDRESS-1:0]      cur_addr_reg;
  logic [ADDRESS:0]        remaining_reg;
  logic                    we_reg;
  logic [ADDRESS-1:0]      waddr_reg;
  logic [COLOR_BITS-1:0]   wdata_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    err_reg;

  logic [ADDRESS:0]        len_clamped;
  logic                    beat;

  assign len_clamped = (length > DEPTH) ? DEPTH : length;
  // Ready depends only on state and abort so the source never sees a loop through s_valid.
  assign s_ready     = (state_reg == LOAD) && !abort;
  assign beat        = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err_reg  <= 1'b0;
            busy_reg <= 1'b1;
            if (len_clamped != '0) begin
              cur_addr_reg  <= base_addr;
              remaining_reg <= len_clamped;
              state_reg     <= LOAD;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (start) begin
            err_reg <= 1'b1;
          end
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else if (beat) begin
            we_reg        <= 1'b1;
            waddr_reg     <= cur_addr_reg;
            wdata_reg     <= s_data;
            cur_addr_reg  <= cur_addr_reg + ADDR_ONE;
            remaining_reg <= remaining_reg - CNT_ONE;
            // done is raised alongside the final write so both land in the same cycle.
            if (remaining_reg == CNT_ONE) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            err_reg <= 1'b1;
          end
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign we    = we_reg;
  assign waddr = waddr_reg;
  assign wdata = wdata_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_tile_writer.sv
// Scoreboard bench for tile_writer: stimulus pushes expected writes, a negedge
// monitor pops and compares them and mirrors writes into a tile-memory model.
module tb_tile_writer;

  localparam int A  = 13;
  localparam int CB = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [A-1:0]  base_addr = '0;
  logic [A:0]    length = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [CB-1:0] s_data = '0;
  logic          s_ready, we, busy, done, err;
  logic [A-1:0]  waddr;
  logic [CB-1:0] wdata;

  tile_writer #(.ADDRESS(A), .COLOR_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A-1:0]  a;
    logic [CB-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [CB-1:0] mem [0:(1<<A)-1];
  int            hits [0:(1<<A)-1];
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            we_cnt = 0;
  int            done_cnt = 0;
  int            done_we = 0;
  int            sready_seen = 0;
  logic [A-1:0]  cur_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic reset_counters();
    we_cnt = 0; done_cnt = 0; done_we = 0; sready_seen = 0;
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ready) sready_seen = 1;
      if (we) begin
        we_cnt++;
        mem[waddr] = wdata;
        hits[waddr]++;
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("waddr", 32'(waddr), 32'(mon_e.a));
          chk("wdata", 32'(wdata), 32'(mon_e.d));
        end
      end
      if (done) begin
        done_cnt++;
        done_we = int'(we);
      end
    end
  end

  task automatic do_start(input logic [A-1:0] b, input logic [A:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    cur_a = b;
  endtask

  // One cycle per pattern bit; bit set means s_valid high and an accepted beat.
  task automatic stream(input logic [31:0] pat, input int n, input logic [CB-1:0] seed);
    for (int i = 0; i < n; i++) begin
      s_valid = pat[i % 32];
      s_data  = seed ^ {{(CB-A){1'b0}}, cur_a};
      if (pat[i % 32]) begin
        exp_q.push_back({cur_a, s_data});
        cur_a = cur_a + 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_we"},      32'(we),      32'd0);
    chk({tag, "_waddr"},   32'(waddr),   32'd0);
    chk({tag, "_wdata"},   32'(wdata),   32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
  endtask

  logic [CB-1:0] bd [4];
  int            bad;

  initial begin
    bd[0] = 24'hFF0000; bd[1] = 24'h00FF00; bd[2] = 24'h0000FF; bd[3] = 24'hFFFFFF;
    for (int i = 0; i < (1<<A); i++) begin mem[i] = '0; hits[i] = 0; end
    #3;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic load
    reset_counters();
    do_start(13'h0010, 14'd4);
    chk("basic_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = bd[i];
      exp_q.push_back({cur_a, bd[i]});
      cur_a = cur_a + 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("basic_busy_after", 32'(busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("basic_mem%0d", i), 32'(mem[16+i]), 32'(bd[i]));
    chk("basic_we_cnt", 32'(we_cnt), 32'd4);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_done_with_we", 32'(done_we), 32'd1);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Wrap and stalls
    reset_counters();
    do_start(13'h1FFE, 14'd4);
    stream(32'b101101, 6, 24'hA50000);
    repeat (3) @(posedge clk); #1;
    chk("wrap_we_cnt", 32'(we_cnt), 32'd4);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);
    chk("wrap_done_with_we", 32'(done_we), 32'd1);
    chk("wrap_hit_1fff", 32'(hits[13'h1FFF]), 32'd1);
    chk("wrap_hit_0001", 32'(hits[1]), 32'd1);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero length
    reset_counters();
    do_start(13'h0040, 14'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("zero_done_drop", 32'(done), 32'd0);
    chk("zero_busy_drop", 32'(busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("zero_we_cnt", 32'(we_cnt), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_no_ready", 32'(sready_seen), 32'd0);

    // Clamped full-memory transfer
    for (int i = 0; i < (1<<A); i++) hits[i] = 0;
    reset_counters();
    do_start(13'h0005, 14'h3FFF);
    stream(32'hFFFFFFFF, 1<<A, 24'h3C0000);
    repeat (3) @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < (1<<A); i++) if (hits[i] != 1) bad++;
    chk("clamp_cover", 32'(bad), 32'd0);
    chk("clamp_we_cnt", 32'(we_cnt), 32'd8192);
    chk("clamp_done_cnt", 32'(done_cnt), 32'd1);
    chk("clamp_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort after three beats
    reset_counters();
    do_start(13'h0200, 14'd8);
    stream(32'b111, 3, 24'h0F0F00);
    s_valid = 1'b1; abort = 1'b1;
    #1 chk("abort_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd1);
    repeat (2) @(posedge clk); #1;
    chk("abort_we_cnt", 32'(we_cnt), 32'd3);
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
    do_start(13'h0210, 14'd1);
    chk("abort_err_cleared", 32'(err), 32'd0);
    stream(32'b1, 1, 24'h123400);
    repeat (2) @(posedge clk); #1;
    chk("abort_next_done", 32'(done_cnt), 32'd1);

    // Start while loading is ignored but flagged
    reset_counters();
    do_start(13'h0300, 14'd4);
    stream(32'b1, 1, 24'h00AA00);
    s_valid = 1'b1; s_data = 24'h00AA00 ^ {{(CB-A){1'b0}}, cur_a};
    exp_q.push_back({cur_a, s_data});
    cur_a = cur_a + 1'b1;
    start = 1'b1; base_addr = 13'h0100;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    chk("cmd_err_set", 32'(err), 32'd1);
    stream(32'b11, 2, 24'h00AA00);
    repeat (3) @(posedge clk); #1;
    chk("cmd_we_cnt", 32'(we_cnt), 32'd4);
    chk("cmd_done_cnt", 32'(done_cnt), 32'd1);
    chk("cmd_err_sticky", 32'(err), 32'd1);
    chk("cmd_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-transfer
    reset_counters();
    do_start(13'h0400, 14'd8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream(32'b11, 2, 24'h777700);
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    reset_counters();
    do_start(13'h0500, 14'd1);
    stream(32'b1, 1, 24'h5A5A00);
    repeat (2) @(posedge clk); #1;
    chk("post_rst_we_cnt", 32'(we_cnt), 32'd1);
    chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);
    chk("post_rst_mem", 32'(mem[13'h0500]), 32'(24'h5A5A00 ^ 24'h000500));
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
